chunk_addr_looper: RTL and testbench
====================================

// Module: chunk_addr_looper
// PURPOSE
//  Consumer end of the chunk-head stream (o_mofs/o_id rdy-ack channel) in the read pipeline.
//  Takes one {mofs[DIM], id} head per transaction and linearizes it with per-config strides.
//  Then walks the chunk word by word, emitting one buffer address per beat on a rdy-ack output.
//  Sits between the chunk-head stage and the global-buffer read-request issuer.
// PARAMETERS
//  ABW     16  width of emitted linear address (result truncated modulo 2^ABW)
//  LEN_BW  8   width of per-config chunk length (words per chunk, 0..2^LEN_BW-1)
//  (WBW, DIM, N_ICFG come from TauCfg; ICFG_BW = $clog2(N_ICFG+1))
// PORTS
//  i_clk           in   1                     clock
//  i_rst           in   1                     synchronous reset, active low
//  i_mofs_rdy      in   1                     head valid
//  i_mofs_ack      out  1                     head accepted this cycle
//  i_mofs          in   WBW x DIM             per-dimension memory offsets of chunk head
//  i_id            in   ICFG_BW               config id of head
//  i_mstrides      in   ABW x N_ICFG x DIM    per-config linear stride for each dimension
//  i_mbase         in   ABW x N_ICFG          per-config buffer base address
//  i_clen          in   LEN_BW x N_ICFG       per-config chunk length in words
//  o_addr_rdy      out  1                     address valid
//  o_addr_ack      in   1                     downstream took address
//  o_addr          out  ABW                   linear buffer address
//  o_id            out  ICFG_BW               config id of current chunk
//  o_last          out  1                     current address is last of chunk
// BEHAVIOUR
//  - Reset (i_rst==0 at posedge): state=IDLE, o_addr=0, o_id=0, cnt=0, o_addr_rdy=0, o_last=0.
//  - rdy-ack rule: ack only while rdy is high; rdy and payload held stable until ack.
//    Downstream may ack in the same cycle rdy rises.
//  - Linearize, combinational on i_mofs/i_id:
//    lin = i_mbase[id] + sum_d(i_mofs[d]*i_mstrides[id][d]).
//    Each product and the sum are truncated to ABW; i_mofs is zero-extended/truncated to ABW first.
//  - FSM states:
//    IDLE: o_addr_rdy=0; i_mofs_ack = i_mofs_rdy.
//    RUN:  o_addr_rdy=1; o_addr = base + cnt (mod 2^ABW); o_last = (cnt == len-1).
//  - Head accept (i_mofs_ack=1): latch base=lin, id=i_id, len=i_clen[i_id], cnt=0.
//    Go to RUN if len!=0; if len==0, consume the head with no output and stay/return IDLE.
//  - In RUN on o_addr_ack:
//    if !o_last: cnt<=cnt+1;
//    else: return to IDLE, unless a head is accepted the same cycle.
//  - Back-to-back: i_mofs_ack = i_mofs_rdy && (IDLE || (o_addr_ack && o_last)).
//    On a last-beat ack with a head present, the new chunk's first address is valid the next cycle.
//    No bubble between chunks.
//  - Latency: head accepted in cycle t -> first o_addr_rdy in t+1.
//    Steady throughput is 1 address/cycle while o_addr_ack is held high.
//  - RUN with o_addr_ack=0: hold o_addr/o_id/o_last stable; config inputs are static per run.
//  - o_id is registered at accept and is constant over the whole chunk.
//  - len = 2^LEN_BW-1 max; cnt never wraps; the address wraps modulo 2^ABW silently.
//  - Reset mid-chunk: the chunk is abandoned and all state returns to reset values next cycle.
//    The upstream head is not re-issued by this block.
// STRUCTURE
//  - TauCfg: DIM, N_ICFG, WBW; add GBUF_ABW (=ABW default) and CLEN_BW (=LEN_BW) constants.
//  - Local typedef enum logic {IDLE, RUN} state_t in this file; not shared.
//  - One sub-module: MofsLinearize#(WBW,ABW,DIM), combinational base + dot product.
//    Reusable by the write pipeline.
// TESTING
//  1 Reset: hold i_rst=0 with i_mofs_rdy=1 -> i_mofs_ack=0, o_addr_rdy=0, all outputs 0.
//  2 Single chunk: DIM=3, mofs={2,1,3}, strides[0]={1,8,64}, mbase[0]=100, clen[0]=4, ack tied 1
//    -> addrs 302,303,304,305; o_last only on 305; o_id=0.
//  3 Back-to-back: two heads queued, id0 len 2, id1 len 1 (base 500)
//    -> beats 302,303,500 on consecutive cycles, o_id changes 0->1 with 500.
//  4 Backpressure: o_addr_ack random 30% -> sequence identical to test 2, payload stable while stalled.
//  5 Zero length: clen[1]=0 head followed by len-2 id0 head -> zero-length head acked in 1 cycle.
//    Only 2 addresses emitted, none with o_id=1.
//  6 Wrap/reset: base 0xFFFE, len 4 -> FFFE,FFFF,0000,0001.
//    Assert i_rst=0 after 2nd beat -> o_addr_rdy=0 next cycle.

Source files
------------

// File: rtl/chunk_addr_looper_pkg.sv
// Shared configuration constants for the chunk read/write pipelines.
// Also provides the beat record carried on the address output channel.
package chunk_addr_looper_pkg;

  localparam int DIM      = 3;
  localparam int N_ICFG   = 2;
  localparam int WBW      = 8;
  localparam int GBUF_ABW = 16;
  localparam int CLEN_BW  = 8;
  localparam int ICFG_BW  = $clog2(N_ICFG + 1);

  typedef struct packed {
    logic [GBUF_ABW-1:0] addr;
    logic [ICFG_BW-1:0]  id;
    logic                last;
  } addr_beat_t;

endpackage

// File: rtl/chunk_addr_looper_linearize.sv
// Combinational base + dot(mofs, strides), all arithmetic wrapping at ABW bits.
// Kept standalone so the write pipeline can reuse the same linearization.
module MofsLinearize #(
  parameter int WBW = 8,
  parameter int ABW = 16,
  parameter int DIM = 3
) (
  input  logic [ABW-1:0]          mbase,
  input  logic [DIM-1:0][WBW-1:0] mofs,
  input  logic [DIM-1:0][ABW-1:0] strides,
  output logic [ABW-1:0]          lin
);

  // Offsets are widened to whichever of WBW/ABW is larger, then cut to ABW.
  localparam int XW = (WBW > ABW) ? WBW : ABW;

  logic [XW-1:0]  wide;
  logic [ABW-1:0] ext;
  logic [ABW-1:0] prod;
  logic [ABW-1:0] acc;

  always_comb begin
    wide = '0;
    ext  = '0;
    prod = '0;
    acc  = mbase;
    for (int d = 0; d < DIM; d++) begin
      wide = XW'(mofs[d]);
      ext  = wide[ABW-1:0];
      prod = ext * strides[d];
      acc  = acc + prod;
    end
    lin = acc;
  end

endmodule

// File: rtl/chunk_addr_looper.sv
// Accepts chunk heads, linearizes them, and walks each chunk emitting one
// buffer address per accepted beat, with no bubble between back-to-back chunks.
module chunk_addr_looper
  import chunk_addr_looper_pkg::*;
#(
  parameter int ABW    = GBUF_ABW,
  parameter int LEN_BW = CLEN_BW
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_mofs_rdy,
  output logic                                i_mofs_ack,
  input  logic [DIM-1:0][WBW-1:0]             i_mofs,
  input  logic [ICFG_BW-1:0]                  i_id,
  input  logic [N_ICFG-1:0][DIM-1:0][ABW-1:0] i_mstrides,
  input  logic [N_ICFG-1:0][ABW-1:0]          i_mbase,
  input  logic [N_ICFG-1:0][LEN_BW-1:0]       i_clen,
  output logic                                o_addr_rdy,
  input  logic                                o_addr_ack,
  output logic [ABW-1:0]                      o_addr,
  output logic [ICFG_BW-1:0]                  o_id,
  output logic                                o_last
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]              state;
  logic [ABW-1:0]          base;
  logic [LEN_BW-1:0]       len;
  logic [LEN_BW-1:0]       cnt;
  logic [ICFG_BW-1:0]      id;

  logic [DIM-1:0][ABW-1:0] sel_strides;
  logic [ABW-1:0]          sel_mbase;
  logic [LEN_BW-1:0]       sel_clen;
  logic [ABW-1:0]          lin;

  // Ids outside the configured range select an all-zero config.
  always_comb begin
    sel_strides = '0;
    sel_mbase   = '0;
    sel_clen    = '0;
    for (int k = 0; k < N_ICFG; k++) begin
      if (i_id == ICFG_BW'(k)) begin
        sel_strides = i_mstrides[k];
        sel_mbase   = i_mbase[k];
        sel_clen    = i_clen[k];
      end
    end
  end

  MofsLinearize #(
    .WBW (WBW),
    .ABW (ABW),
    .DIM (DIM)
  ) u_linearize (
    .mbase   (sel_mbase),
    .mofs    (i_mofs),
    .strides (sel_strides),
    .lin     (lin)
  );

  assign o_addr_rdy = (state == RUN);
  assign o_last     = (state == RUN) && (cnt == len - 1'b1);
  assign o_addr     = base + ABW'(cnt);
  assign o_id       = id;

  // A new head may replace the chunk on the very cycle its last beat is taken.
  assign i_mofs_ack = i_rst && i_mofs_rdy &&
                      ((state == IDLE) || (o_addr_ack && o_last));

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= IDLE;
      base  <= '0;
      id    <= '0;
      len   <= '0;
      cnt   <= '0;
    end else if (i_mofs_ack) begin
      base  <= lin;
      id    <= i_id;
      len   <= sel_clen;
      cnt   <= '0;
      state <= (sel_clen != '0) ? RUN : IDLE;
    end else if ((state == RUN) && o_addr_ack) begin
      if (o_last) begin
        state <= IDLE;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_chunk_addr_looper.sv
// Scoreboard bench: stimulus pushes hand-computed beats, a negedge monitor pops
// and compares every accepted address and checks payload stability while stalled.
module tb_chunk_addr_looper;
  import chunk_addr_looper_pkg::*;

  localparam int ABW    = GBUF_ABW;
  localparam int LEN_BW = CLEN_BW;

  logic                                clk = 1'b0;
  logic                                i_rst;
  logic                                i_mofs_rdy;
  logic                                i_mofs_ack;
  logic [DIM-1:0][WBW-1:0]             i_mofs;
  logic [ICFG_BW-1:0]                  i_id;
  logic [N_ICFG-1:0][DIM-1:0][ABW-1:0] i_mstrides;
  logic [N_ICFG-1:0][ABW-1:0]          i_mbase;
  logic [N_ICFG-1:0][LEN_BW-1:0]       i_clen;
  logic                                o_addr_rdy;
  logic                                o_addr_ack;
  logic [ABW-1:0]                      o_addr;
  logic [ICFG_BW-1:0]                  o_id;
  logic                                o_last;

  addr_beat_t exp_q[$];
  int         check_count = 0;
  int         pass_count  = 0;
  int         beats_seen  = 0;
  int         ack_mode    = 0;
  logic       prev_stall  = 1'b0;
  addr_beat_t prev_beat;

  always #5 clk = ~clk;

  chunk_addr_looper #(
    .ABW    (ABW),
    .LEN_BW (LEN_BW)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_mofs_rdy (i_mofs_rdy),
    .i_mofs_ack (i_mofs_ack),
    .i_mofs     (i_mofs),
    .i_id       (i_id),
    .i_mstrides (i_mstrides),
    .i_mbase    (i_mbase),
    .i_clen     (i_clen),
    .o_addr_rdy (o_addr_rdy),
    .o_addr_ack (o_addr_ack),
    .o_addr     (o_addr),
    .o_id       (o_id),
    .o_last     (o_last)
  );

  task automatic record(input string name, input bit ok, input string detail);
    check_count++;
    if (ok) pass_count++;
    else $display("[TB] FAIL %s: %s", name, detail);
  endtask

  task automatic expect_beat(input logic [ABW-1:0] addr, input logic [ICFG_BW-1:0] id,
                             input logic last);
    addr_beat_t b;
    b.addr = addr;
    b.id   = id;
    b.last = last;
    exp_q.push_back(b);
  endtask

  task automatic checkOutput();
    addr_beat_t got;
    addr_beat_t want;
    got.addr = o_addr;
    got.id   = o_id;
    got.last = o_last;
    if (exp_q.size() == 0) begin
      record("unexpected_beat", 1'b0,
             $sformatf("got addr=%h id=%0d last=%0b, required no beat", got.addr, got.id, got.last));
    end else begin
      want = exp_q.pop_front();
      record("beat", got == want,
             $sformatf("got addr=%h id=%0d last=%0b, required addr=%h id=%0d last=%0b",
                       got.addr, got.id, got.last, want.addr, want.id, want.last));
    end
    beats_seen++;
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    addr_beat_t cur;
    cur.addr = o_addr;
    cur.id   = o_id;
    cur.last = o_last;
    if (i_rst === 1'b1) begin
      if (prev_stall) begin
        record("stall_hold", o_addr_rdy && (cur == prev_beat),
               $sformatf("got rdy=%0b addr=%h id=%0d last=%0b, required rdy=1 addr=%h id=%0d last=%0b",
                         o_addr_rdy, cur.addr, cur.id, cur.last,
                         prev_beat.addr, prev_beat.id, prev_beat.last));
      end
      if (o_addr_rdy && o_addr_ack) checkOutput();
      prev_stall = o_addr_rdy && !o_addr_ack;
      prev_beat  = cur;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Downstream acceptor: 0 = always ready, 1 = ready ~30% of cycles, 2 = never.
  initial begin
    o_addr_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ack_mode)
        0:       o_addr_ack = 1'b1;
        1:       o_addr_ack = ($urandom_range(0, 99) < 30);
        default: o_addr_ack = 1'b0;
      endcase
    end
  end

  // Presents one head and waits for its ack; returns the cycles spent waiting.
  task automatic applyStimulus(input logic [DIM-1:0][WBW-1:0] mofs, input logic [ICFG_BW-1:0] id,
                               input bit keep_rdy, output int waits);
    i_mofs     = mofs;
    i_id       = id;
    i_mofs_rdy = 1'b1;
    waits      = 0;
    forever begin
      @(negedge clk);
      if (i_mofs_ack) break;
      waits++;
      if (waits > 200) begin
        record("head_timeout", 1'b0, "got no i_mofs_ack within 200 cycles, required ack");
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!keep_rdy) i_mofs_rdy = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !o_addr_rdy) begin
        done = 1'b1;
        break;
      end
    end
    record(name, done,
           $sformatf("got %0d beats outstanding rdy=%0b, required 0 outstanding rdy=0",
                     exp_q.size(), o_addr_rdy));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DIM-1:0][WBW-1:0] m;
    logic [DIM-1:0][WBW-1:0] zero_m;
    int  waits;
    int  target;
    bit  reached;

    m[0] = 8'd2;
    m[1] = 8'd1;
    m[2] = 8'd3;
    zero_m = '0;

    i_rst      = 1'b0;
    i_mofs_rdy = 1'b1;
    i_mofs     = m;
    i_id       = '0;
    i_mstrides = '0;
    i_mstrides[0][0] = 16'd1;
    i_mstrides[0][1] = 16'd8;
    i_mstrides[0][2] = 16'd64;
    i_mbase    = '0;
    i_mbase[0] = 16'd100;
    i_mbase[1] = 16'd500;
    i_clen     = '0;
    i_clen[0]  = 8'd4;
    i_clen[1]  = 8'd1;

    $display("[TB] test 1: reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    record("rst_mofs_ack", i_mofs_ack == 1'b0, $sformatf("got %0b, required 0", i_mofs_ack));
    record("rst_addr_rdy", o_addr_rdy == 1'b0, $sformatf("got %0b, required 0", o_addr_rdy));
    record("rst_addr", o_addr == '0, $sformatf("got %h, required 0000", o_addr));
    record("rst_id", o_id == '0, $sformatf("got %0d, required 0", o_id));
    record("rst_last", o_last == 1'b0, $sformatf("got %0b, required 0", o_last));
    @(posedge clk);
    #1;
    i_mofs_rdy = 1'b0;
    i_rst      = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] test 2: single chunk");
    expect_beat(16'd302, 2'd0, 1'b0);
    expect_beat(16'd303, 2'd0, 1'b0);
    expect_beat(16'd304, 2'd0, 1'b0);
    expect_beat(16'd305, 2'd0, 1'b1);
    applyStimulus(m, 2'd0, 1'b0, waits);
    @(negedge clk);
    record("latency", o_addr_rdy == 1'b1, $sformatf("got rdy=%0b one cycle after accept, required 1", o_addr_rdy));
    drain("drain_single");

    $display("[TB] test 3: back-to-back");
    i_clen[0] = 8'd2;
    expect_beat(16'd302, 2'd0, 1'b0);
    expect_beat(16'd303, 2'd0, 1'b1);
    expect_beat(16'd500, 2'd1, 1'b1);
    applyStimulus(m, 2'd0, 1'b1, waits);
    applyStimulus(zero_m, 2'd1, 1'b0, waits);
    record("b2b_accept", waits == 1, $sformatf("got %0d wait cycles, required 1", waits));
    @(negedge clk);
    record("b2b_no_bubble", o_addr_rdy && o_addr == 16'd500,
           $sformatf("got rdy=%0b addr=%h, required rdy=1 addr=01f4", o_addr_rdy, o_addr));
    drain("drain_b2b");

    $display("[TB] test 4: backpressure");
    i_clen[0] = 8'd4;
    ack_mode  = 1;
    expect_beat(16'd302, 2'd0, 1'b0);
    expect_beat(16'd303, 2'd0, 1'b0);
    expect_beat(16'd304, 2'd0, 1'b0);
    expect_beat(16'd305, 2'd0, 1'b1);
    applyStimulus(m, 2'd0, 1'b0, waits);
    drain("drain_backpressure");
    ack_mode = 0;
    @(posedge clk);
    #1;

    $display("[TB] test 5: zero length");
    i_clen[0] = 8'd2;
    i_clen[1] = 8'd0;
    expect_beat(16'd302, 2'd0, 1'b0);
    expect_beat(16'd303, 2'd0, 1'b1);
    applyStimulus(zero_m, 2'd1, 1'b1, waits);
    record("zero_len_ack", waits == 0, $sformatf("got %0d wait cycles, required 0", waits));
    applyStimulus(m, 2'd0, 1'b0, waits);
    record("zero_len_next", waits == 0, $sformatf("got %0d wait cycles, required 0", waits));
    drain("drain_zero_len");

    $display("[TB] test 6: wrap and mid-chunk reset");
    i_mbase[0] = 16'hFFFE;
    i_clen[0]  = 8'd4;
    expect_beat(16'hFFFE, 2'd0, 1'b0);
    expect_beat(16'hFFFF, 2'd0, 1'b0);
    target = beats_seen + 2;
    applyStimulus(zero_m, 2'd0, 1'b0, waits);
    reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (beats_seen >= target) begin
        reached = 1'b1;
        break;
      end
    end
    record("wrap_beats", reached && exp_q.size() == 0,
           $sformatf("got %0d of 2 beats, required 2", beats_seen - target + 2));
    #1;
    i_rst    = 1'b0;
    ack_mode = 2;
    @(posedge clk);
    @(negedge clk);
    record("midrst_addr_rdy", o_addr_rdy == 1'b0, $sformatf("got %0b, required 0", o_addr_rdy));
    record("midrst_addr", o_addr == '0, $sformatf("got %h, required 0000", o_addr));
    record("midrst_last", o_last == 1'b0, $sformatf("got %0b, required 0", o_last));
    record("midrst_id", o_id == '0, $sformatf("got %0d, required 0", o_id));
    @(posedge clk);
    #1;
    i_rst    = 1'b1;
    ack_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    record("final_idle", o_addr_rdy == 1'b0 && exp_q.size() == 0,
           $sformatf("got rdy=%0b outstanding=%0d, required rdy=0 outstanding=0", o_addr_rdy, exp_q.size()));

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
